// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - LSU LCD register window bus between the core and the LCD timing engine
interface lcd_ctrl_if;
    logic        wr;
    logic [31:0] wdata;
    logic        clr_ovf;
    logic [31:0] status;

    modport master (output wr, output wdata, output clr_ovf, input status);
    modport slave  (input wr, input wdata, input clr_ovf, output status);
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style LCD timing engine with a one-entry pending byte slot
module lcd_ctrl #(
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000,
    parameter int CNT_W       = 17
) (
    input  logic             i_clk,
    input  logic             i_reset,
    lcd_ctrl_if.slave        bus,
    output logic [7:0]       o_lcd_data,
    output logic             o_lcd_rs,
    output logic             o_lcd_rw,
    output logic             o_lcd_en,
    output logic             o_lcd_on,
    output logic             o_lcd_blon
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4
    } state_t;

    // Counter is loaded with (duration - 1) on state entry and advances at zero
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       act_data;
    logic             act_rs;
    logic [7:0]       pend_data;
    logic             pend_rs;
    logic             pend_vld;
    logic             ovf;
    logic             en_q;
    logic             on_q;
    logic             blon_q;
    logic             busy;

    logic             cmd_wr;
    logic             last_exec;
    logic             exec_long;
    logic             ovf_set;
    logic             unused_wdata;

    assign cmd_wr       = bus.wr & bus.wdata[9];
    assign last_exec    = (state == EXEC) && (cnt == '0);
    assign exec_long    = !act_rs && ((act_data == 8'h01) || (act_data == 8'h02) || (act_data == 8'h03));
    assign ovf_set      = cmd_wr && (state != IDLE) && pend_vld && !last_exec;
    assign unused_wdata = ^bus.wdata[29:10];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            act_data  <= 8'h00;
            act_rs    <= 1'b0;
            pend_data <= 8'h00;
            pend_rs   <= 1'b0;
            pend_vld  <= 1'b0;
            ovf       <= 1'b0;
            en_q      <= 1'b0;
            on_q      <= 1'b0;
            blon_q    <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            // EN comes straight from a flop so the pin never glitches
            en_q  <= (next_state == EN_HI);

            if (bus.wr) begin
                on_q   <= bus.wdata[31];
                blon_q <= bus.wdata[30];
            end

            if (state == IDLE) begin
                if (cmd_wr) begin
                    act_data <= bus.wdata[7:0];
                    act_rs   <= bus.wdata[8];
                end
            end else if (last_exec) begin
                if (pend_vld) begin
                    act_data <= pend_data;
                    act_rs   <= pend_rs;
                    if (cmd_wr) begin
                        pend_data <= bus.wdata[7:0];
                        pend_rs   <= bus.wdata[8];
                    end else begin
                        pend_vld <= 1'b0;
                    end
                end else if (cmd_wr) begin
                    act_data <= bus.wdata[7:0];
                    act_rs   <= bus.wdata[8];
                end
            end else if (cmd_wr && !pend_vld) begin
                pend_data <= bus.wdata[7:0];
                pend_rs   <= bus.wdata[8];
                pend_vld  <= 1'b1;
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (cmd_wr) begin
                    next_state = SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    next_state = EN_HI;
                    cnt_next   = LD_EN;
                end
            end
            EN_HI: begin
                if (cnt == '0) begin
                    next_state = HOLD;
                    cnt_next   = LD_HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    next_state = EXEC;
                    cnt_next   = exec_long ? LD_LONG : LD_EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    if (pend_vld || cmd_wr) begin
                        next_state = SETUP;
                        cnt_next   = LD_SETUP;
                    end else begin
                        next_state = IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state != IDLE) || pend_vld;
        bus.status = {29'd0, ovf, pend_vld, busy};
    end

    assign o_lcd_data = act_data;
    assign o_lcd_rs   = act_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_blon = blon_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;
    logic       clk;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       lcd_blon;

    int total = 0;
    int bad   = 0;

    lcd_ctrl_if bus_if ();

    lcd_ctrl #(
        .T_SETUP     (2),
        .T_EN        (3),
        .T_HOLD      (2),
        .T_EXEC      (10),
        .T_EXEC_LONG (40),
        .CNT_W       (17)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .bus        (bus_if.slave),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on),
        .o_lcd_blon (lcd_blon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] w);
        bus_if.wdata = w;
        bus_if.wr    = 1'b1;
        step();
        bus_if.wr    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus_if.status[0] && n < 500) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus_if.status[0]}, 32'd0);
    endtask

    task automatic busy_len(input logic [31:0] w, input logic [31:0] exp, input string tag);
        int n = 0;
        wr_word(w);
        while (bus_if.status[0] && n < 200) begin
            n++;
            step();
        end
        chk(tag, n, exp);
    endtask

    initial begin
        logic [31:0] en_mask;
        logic [31:0] busy_mask;
        int n;

        reset          = 1'b0;
        bus_if.wr      = 1'b0;
        bus_if.wdata   = 32'd0;
        bus_if.clr_ovf = 1'b0;

        // 1: reset
        step();
        step();
        chk("rst_status", bus_if.status, 32'd0);
        chk("rst_pins", {lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon}, 32'd0);
        reset = 1'b1;
        step();

        // 2: single transfer latency
        wr_word(32'h8000_0241);
        chk("t2_on", {31'd0, lcd_on}, 32'd1);
        chk("t2_data", {23'd0, lcd_rs, lcd_data}, 32'h41);
        en_mask   = 32'd0;
        busy_mask = 32'd0;
        for (int i = 1; i <= 24; i++) begin
            en_mask[i]   = lcd_en;
            busy_mask[i] = bus_if.status[0];
            step();
        end
        chk("t2_en_window", en_mask, 32'h0000_0038);
        chk("t2_busy_window", busy_mask, 32'h0003_fffe);

        // 3: long vs short execution wait
        busy_len(32'h0000_0201, 32'd47, "t3_clear_long");
        busy_len(32'h0000_0301, 32'd17, "t3_rs1_short");
        busy_len(32'h0000_0203, 32'd47, "t3_home_long");
        busy_len(32'h0000_0204, 32'd17, "t3_cmd4_short");

        // 4: pending fill and overflow
        wr_word(32'h0000_020A);
        wr_word(32'h0000_020B);
        wr_word(32'h0000_020C);
        chk("t4_status_ovf", bus_if.status, 32'd7);
        chk("t4_data_a", {24'd0, lcd_data}, 32'h0A);
        bus_if.clr_ovf = 1'b1;
        step();
        bus_if.clr_ovf = 1'b0;
        chk("t4_status_clr", bus_if.status, 32'd3);
        n = 0;
        while (lcd_data != 8'h0B && n < 100) begin
            step();
            n++;
        end
        chk("t4_b_latency", n, 32'd14);
        wait_idle("t4_idle");
        chk("t4_status_end", bus_if.status, 32'd0);

        // 5a: write on last EXEC cycle with pending valid
        wr_word(32'h0000_020A);
        wr_word(32'h0000_020B);
        repeat (15) step();
        wr_word(32'h0000_020D);
        chk("t5a_data_b", {24'd0, lcd_data}, 32'h0B);
        chk("t5a_status", bus_if.status, 32'd3);
        n = 0;
        while (lcd_data != 8'h0D && n < 100) begin
            step();
            n++;
        end
        chk("t5a_d_latency", n, 32'd17);
        wait_idle("t5a_idle");
        chk("t5a_no_ovf", bus_if.status, 32'd0);

        // 5b: write on last EXEC cycle with pending empty
        wr_word(32'h0000_020A);
        repeat (16) step();
        wr_word(32'h0000_020D);
        chk("t5b_data_d", {24'd0, lcd_data}, 32'h0D);
        chk("t5b_status", bus_if.status, 32'd1);
        step();
        chk("t5b_setup_en", {31'd0, lcd_en}, 32'd0);
        step();
        chk("t5b_en_rise", {31'd0, lcd_en}, 32'd1);
        wait_idle("t5b_idle");

        // 6: reset during EN_HI, then a CMD=0 write
        wr_word(32'h0000_020E);
        wr_word(32'h0000_020F);
        wr_word(32'h0000_0210);
        chk("t6_en_hi", {31'd0, lcd_en}, 32'd1);
        chk("t6_status_pre", bus_if.status, 32'd7);
        reset = 1'b0;
        step();
        chk("t6_rst_en", {31'd0, lcd_en}, 32'd0);
        chk("t6_rst_status", bus_if.status, 32'd0);
        chk("t6_rst_data", {24'd0, lcd_data}, 32'd0);
        reset = 1'b1;
        wr_word(32'h4000_0000);
        chk("t6_blon", {30'd0, lcd_on, lcd_blon}, 32'd1);
        chk("t6_no_xfer", bus_if.status, 32'd0);
        en_mask = 32'd0;
        for (int i = 0; i < 8; i++) begin
            en_mask[i] = lcd_en | bus_if.status[0];
            step();
        end
        chk("t6_quiet", en_mask, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
